prf_multiport: RTL

PRF_MULTIPORT -- requirements
Module: prf_multiport

---
 rtl/backend_types.sv | 7 +
 rtl/prf_multiport_if.sv | 27 ++
 rtl/prf_bypass_mux.sv | 26 ++
 rtl/prf_multiport.sv | 70 +++++++
 4 files changed

// File: rtl/backend_types.sv
// backend_types: shared back-end widths and the physical-register index type
package backend_types;
    localparam int NUM_PHYS_REGISTERS = 64;
    localparam int DATA_W = 32;
    localparam int PW = $clog2(NUM_PHYS_REGISTERS);
    typedef logic [PW-1:0] preg_t;
endpackage

// File: rtl/prf_multiport_if.sv
// prf_multiport_if: read, rename-allocate and CDB write bundle of the physical register file
interface prf_multiport_if #(
    parameter int NUM_PREGS = backend_types::NUM_PHYS_REGISTERS,
    parameter int DATA_W = backend_types::DATA_W,
    parameter int NUM_RD = 4,
    parameter int NUM_WR = 2
);
    localparam int PW = $clog2(NUM_PREGS);
    logic [NUM_RD-1:0][PW-1:0] rd_addr;
    logic [NUM_RD-1:0][DATA_W-1:0] rd_data;
    logic [NUM_RD-1:0] rd_ready;
    logic alloc_valid;
    logic [PW-1:0] alloc_preg;
    logic [NUM_WR-1:0] wr_valid;
    logic [NUM_WR-1:0][PW-1:0] wr_preg;
    logic [NUM_WR-1:0][DATA_W-1:0] wr_data;
    logic flush;
    logic wr_conflict;
    modport master (
        output rd_addr, alloc_valid, alloc_preg, wr_valid, wr_preg, wr_data, flush,
        input rd_data, rd_ready, wr_conflict
    );
    modport slave (
        input rd_addr, alloc_valid, alloc_preg, wr_valid, wr_preg, wr_data, flush,
        output rd_data, rd_ready, wr_conflict
    );
endinterface

// File: rtl/prf_bypass_mux.sv
// prf_bypass_mux: forwards a same-cycle CDB result to one read port, lowest write port winning
module prf_bypass_mux #(
    parameter int PW = 6,
    parameter int DATA_W = 32,
    parameter int NUM_WR = 2
) (
    input  logic [PW-1:0] addr,
    input  logic [NUM_WR-1:0] wr_valid,
    input  logic [NUM_WR-1:0][PW-1:0] wr_preg,
    input  logic [NUM_WR-1:0][DATA_W-1:0] wr_data,
    input  logic [DATA_W-1:0] sdata,
    input  logic sready,
    output logic [DATA_W-1:0] data,
    output logic ready
);
    // descending scan so the lowest matching port is the last to assign
    always_comb begin
        data = sdata;
        ready = sready;
        for (int j = NUM_WR - 1; j >= 0; j--)
            if (wr_valid[j] && wr_preg[j] == addr && addr != '0) begin
                data = wr_data[j];
                ready = 1'b1;
            end
    end
endmodule

// File: rtl/prf_multiport.sv
// prf_multiport: multi-port physical register file with ready bits and CDB writes.
// Define PRF_BYPASS_EN to forward same-cycle CDB results to the read ports.
module prf_multiport
    import backend_types::NUM_PHYS_REGISTERS;
    import backend_types::preg_t;
#(
    parameter int NUM_PREGS = NUM_PHYS_REGISTERS,
    parameter int DATA_W = backend_types::DATA_W,
    parameter int NUM_RD = 4,
    parameter int NUM_WR = 2
) (
    input logic clk,
    input logic rst,
    prf_multiport_if.slave bus
);
    localparam int PW = $clog2(NUM_PREGS);
    logic [DATA_W-1:0] data [NUM_PREGS];
    logic [NUM_PREGS-1:0] ready;
    logic conflict;
    logic [NUM_WR-1:0] live, clash, win;
    logic [NUM_RD-1:0][DATA_W-1:0] bd;
    logic [NUM_RD-1:0] br;
    // a port clashes when a lower-index live port targets the same register
    always_comb begin
        clash = '0;
        for (int j = 0; j < NUM_WR; j++) live[j] = bus.wr_valid[j] && bus.wr_preg[j] != '0;
        for (int j = 0; j < NUM_WR; j++)
            for (int k = 0; k < j; k++)
                if (live[j] && live[k] && bus.wr_preg[k] == bus.wr_preg[j]) clash[j] = 1'b1;
        win = live & ~clash;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_PREGS; i++) data[i] <= '0;
            ready <= '1;
            conflict <= 1'b0;
        end else begin
            for (int j = 0; j < NUM_WR; j++)
                if (win[j]) begin
                    data[bus.wr_preg[j]] <= bus.wr_data[j];
                    ready[bus.wr_preg[j]] <= 1'b1;
                end
            if (bus.alloc_valid && bus.alloc_preg != '0) ready[bus.alloc_preg] <= 1'b0;
            if (bus.flush) ready <= '1;
            conflict <= conflict | (|clash);
        end
    end
    for (genvar r = 0; r < NUM_RD; r++) begin : g_rd
        logic [PW-1:0] a;
        logic [DATA_W-1:0] sd;
        logic sr;
        assign a = bus.rd_addr[r];
        assign sd = a == '0 ? '0 : data[a];
        assign sr = a == '0 || ready[a];
`ifdef PRF_BYPASS_EN
        prf_bypass_mux #(.PW(PW), .DATA_W(DATA_W), .NUM_WR(NUM_WR)) u_byp (
            .addr(a), .wr_valid(bus.wr_valid), .wr_preg(bus.wr_preg), .wr_data(bus.wr_data),
            .sdata(sd), .sready(sr), .data(bd[r]), .ready(br[r])
        );
`else
        assign bd[r] = sd;
        assign br[r] = sr;
`endif
    end
    always_comb begin
        bus.rd_data = rst ? '0 : bd;
        bus.rd_ready = rst ? '0 : br;
    end
    assign bus.wr_conflict = conflict;
endmodule
